fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end of the CPU. Owns the program counter, issues single-outstanding read requests to instruction memory over a req/ack handshake, and delivers {pc, instruction} pairs downstream through a 2-entry buffer with a valid/ready handshake. A branch/jump redirect flushes buffered and in-flight fetches and restarts fetch at the target PC.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- PC_STEP, 4, byte increment between sequential fetches
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; stable while imem_req high
- imem_ack  input  1  memory has returned imem_data this cycle; may be high in the same cycle as imem_req
- imem_data  input  32  fetched instruction, valid when imem_ack
- redirect_valid  input  1  one-cycle redirect strobe from execute
- redirect_pc  input  32  redirect target
- out_valid  output  1  head buffer entry valid
- out_pc  output  32  PC of head entry
- out_instr  output  32  instruction of head entry
- out_ready  input  1  downstream accepts head entry this cycle

## Operation
- State: IDLE, FETCH, DRAIN. Registers: pc (next fetch address), addr_q (outstanding address), 2-entry FIFO of {pc, instr}, count 0..2.
- Reset: state IDLE, pc=RESET_PC, count=0, out_valid=0, out_pc=0, out_instr=0, imem_req=0, imem_addr=0.
- IDLE -> FETCH unconditionally on the first posedge after rst deasserts.
- FETCH: imem_req = (count<2); imem_addr = pc. Once raised, imem_req stays high with the same address until imem_ack (count cannot grow without ack). On ack: push {pc, imem_data}, pc <= pc + PC_STEP (mod 2^32).
- Pop: out_valid && out_ready removes head. Push and pop in the same cycle: count unchanged, order preserved.
- Redirect, no request outstanding or ack in the same cycle: FIFO flushed, ack data dropped, pc <= redirect_pc, stay FETCH.
- Redirect, request outstanding and no ack: FIFO flushed, addr_q holds old address, pc <= redirect_pc, go DRAIN.
- DRAIN: imem_req=1, imem_addr=addr_q. On ack: data discarded, -> FETCH (fetches pc). Redirect while in DRAIN: pc <= newest redirect_pc, remain DRAIN unless ack in the same cycle.
- Redirect coincident with out_valid && out_ready: head counts as consumed; the flush still empties the FIFO.
- rst asserted mid-transaction: immediate return to reset values; the outstanding memory request is abandoned.

## Timing
- First imem_req: cycle 1 after reset release (IDLE occupies cycle 0).
- Ack-to-out_valid latency: 1 cycle (registered FIFO).
- Zero-wait memory (ack same cycle as req) with out_ready=1: one instruction per cycle.
- Redirect-to-first-fetch at target: next cycle if nothing outstanding; otherwise the cycle after the draining ack.
- out_valid deasserts the cycle after a redirect.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: adds output misalign_err (1 bit, reset 0). redirect_pc[1:0] is forced to 2'b00 before use; misalign_err pulses high for one cycle, the cycle after a redirect with nonzero redirect_pc[1:0].
- Undefined: redirect_pc used unmodified, no misalign_err port.

## Structure
- Shared cpu_pkg: state encoding (IDLE/FETCH/DRAIN), RESET_PC default, PC_STEP, instruction/PC width constant (32).
- One sub-module: fetch_fifo (2-entry, push/pop/flush, count output).

## Test plan
- Reset release, RESET_PC=0, zero-wait memory, out_ready=1 -> imem_req high from cycle 1; out_pc 0,4,8,12 on consecutive cycles.
- out_ready=0 -> exactly two entries (pc 0, 4) buffered, imem_req low; raising out_ready resumes at pc 8 with no loss or duplication.
- 3-cycle memory latency, redirect_pc=0x100 in the second wait cycle -> imem_addr held at old address until ack, data dropped, next request at 0x100, first out_pc=0x100.
- Redirect to 0x200 with same-cycle ack and out_ready=1, FIFO holding 2 entries -> all dropped, out_valid low next cycle, next fetch at 0x200.
- pc=0xFFFF_FFFC, ack -> next fetch address 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x103 -> fetch at 0x100, misalign_err high for one cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM encoding, PC defaults and
// the {pc, instr} entry carried through the fetch buffer.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack, redirect strobe and the
// downstream valid/ready port. master = fetch unit side.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr,
        input  imem_ack, imem_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr,
        output imem_ack, imem_data, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer with push, pop and flush. The head entry is
// visible combinationally so a push shows up on the output one cycle later.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         push_ok;
    logic         pop_ok;

    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            // Flush beats any coincident push or pop.
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem request, redirect
// flush/drain and a 2-entry output buffer. Option: FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    fetch_unit_if.master bus
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic misalign_err
`endif
);

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] addr_q_reg, addr_q_next;
    logic [XLEN-1:0] target_pc;
    logic            req;
    logic [XLEN-1:0] addr;
    logic            push;
    logic            pop;
    logic            flush;
    fetch_entry_t    head;
    logic [1:0]      count;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_reg;

    assign target_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_reg;
`else
    assign target_pc = bus.redirect_pc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            addr_q_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            addr_q_reg <= addr_q_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        addr_q_next = addr_q_reg;
        req         = 1'b0;
        addr        = '0;
        push        = 1'b0;
        flush       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // count cannot grow without an ack, so req/addr stay stable once raised
                req  = (count != 2'd2);
                addr = pc_reg;
                if (bus.redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = target_pc;
                    if (req && !bus.imem_ack) begin
                        addr_q_next = pc_reg;
                        state_next  = ST_DRAIN;
                    end
                end else if (req && bus.imem_ack) begin
                    push    = 1'b1;
                    pc_next = pc_reg + PC_STEP;
                end
            end
            ST_DRAIN: begin
                // Keep the abandoned request alive until memory answers; data is dropped.
                req  = 1'b1;
                addr = addr_q_reg;
                if (bus.redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = target_pc;
                end
                if (bus.imem_ack) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pop = (count != 2'd0) && bus.out_ready;

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ('{pc: pc_reg, instr: bus.imem_data}),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = addr;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side memory responder (zero-wait or
// fixed wait states), cycle-by-cycle checks sampled just after negedge.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_err;
`endif

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    // Memory responder: instruction word = address ^ 32'h1357_9BDF.
    logic zw;
    int   waits;
    int   wait_cnt;

    assign bus.imem_ack  = bus.imem_req && (zw || (wait_cnt == waits));
    assign bus.imem_data = bus.imem_addr ^ 32'h1357_9BDF;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (bus.imem_req && !bus.imem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        zw                 = 1'b1;
        waits              = 0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;

        // ---- reset values ----
        repeat (2) cyc();
        settle();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc",    bus.out_pc,         32'h0);
        check("rst_out_instr", bus.out_instr,      32'h0);
        check("rst_imem_req",  32'(bus.imem_req),  32'd0);
        check("rst_imem_addr", bus.imem_addr,      32'h0);

        // ---- zero-wait streaming, out_ready=1 ----
        cyc(); rst = 1'b0; settle();
        $display("T1 c0 idle");
        check("t1_c0_req", 32'(bus.imem_req), 32'd0);
        cyc(); settle();
        check("t1_c1_req",  32'(bus.imem_req), 32'd1);
        check("t1_c1_addr", bus.imem_addr,     32'h0);
        check("t1_c1_ov",   32'(bus.out_valid), 32'd0);
        cyc(); settle();
        check("t1_c2_ov",    32'(bus.out_valid), 32'd1);
        check("t1_c2_pc",    bus.out_pc,    32'h0);
        check("t1_c2_instr", bus.out_instr, 32'h1357_9BDF);
        check("t1_c2_addr",  bus.imem_addr, 32'h4);
        cyc(); settle();
        check("t1_c3_pc", bus.out_pc, 32'h4);
        cyc(); settle();
        check("t1_c4_pc", bus.out_pc, 32'h8);
        cyc(); settle();
        check("t1_c5_pc",    bus.out_pc,    32'hC);
        check("t1_c5_instr", bus.out_instr, 32'h1357_9BD3);

        // ---- asynchronous reset mid-stream ----
        cyc(); rst = 1'b1; bus.out_ready = 1'b0; settle();
        $display("T2 async reset");
        check("t2_rst_ov",   32'(bus.out_valid), 32'd0);
        check("t2_rst_req",  32'(bus.imem_req),  32'd0);
        check("t2_rst_addr", bus.imem_addr,      32'h0);

        // ---- backpressure: two entries then stall ----
        cyc(); rst = 1'b0; settle();
        cyc(); settle();
        check("t2_c1_addr", bus.imem_addr, 32'h0);
        cyc(); settle();
        check("t2_c2_addr", bus.imem_addr, 32'h4);
        check("t2_c2_pc",   bus.out_pc,    32'h0);
        cyc(); settle();
        check("t2_c3_req", 32'(bus.imem_req),  32'd0);
        check("t2_c3_ov",  32'(bus.out_valid), 32'd1);
        cyc(); settle();
        check("t2_c4_req", 32'(bus.imem_req), 32'd0);
        check("t2_c4_pc",  bus.out_pc,        32'h0);
        cyc(); bus.out_ready = 1'b1; settle();
        check("t2_c5_pc",  bus.out_pc,        32'h0);
        check("t2_c5_req", 32'(bus.imem_req), 32'd0);
        cyc(); settle();
        check("t2_c6_pc",   bus.out_pc,        32'h4);
        check("t2_c6_req",  32'(bus.imem_req), 32'd1);
        check("t2_c6_addr", bus.imem_addr,     32'h8);
        cyc(); settle();
        check("t2_c7_pc", bus.out_pc, 32'h8);
        cyc(); settle();
        check("t2_c8_pc", bus.out_pc, 32'hC);

        // ---- 3 wait states, redirect in second wait cycle ----
        cyc(); rst = 1'b1; zw = 1'b0; waits = 3; settle();
        cyc(); rst = 1'b0; settle();
        $display("T3 latency redirect");
        cyc(); settle();
        check("t3_c1_addr", bus.imem_addr, 32'h0);
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; settle();
        check("t3_c2_addr", bus.imem_addr, 32'h0);
        cyc(); bus.redirect_valid = 1'b0; settle();
        check("t3_c3_req",  32'(bus.imem_req),  32'd1);
        check("t3_c3_addr", bus.imem_addr,      32'h0);
        check("t3_c3_ov",   32'(bus.out_valid), 32'd0);
        cyc(); settle();
        check("t3_c4_addr", bus.imem_addr, 32'h0);
        cyc(); settle();
        check("t3_c5_addr", bus.imem_addr,      32'h100);
        check("t3_c5_ov",   32'(bus.out_valid), 32'd0);
        repeat (3) cyc();
        settle();
        check("t3_c8_ov", 32'(bus.out_valid), 32'd0);
        cyc(); settle();
        check("t3_c9_ov",    32'(bus.out_valid), 32'd1);
        check("t3_c9_pc",    bus.out_pc,    32'h100);
        check("t3_c9_instr", bus.out_instr, 32'h1357_9ADF);

        // ---- redirect with full FIFO, then with same-cycle ack, then PC wrap ----
        cyc(); rst = 1'b1; zw = 1'b1; waits = 0; bus.out_ready = 1'b0; settle();
        cyc(); rst = 1'b0; settle();
        $display("T4 flush redirect");
        cyc(); settle();
        cyc(); settle();
        cyc(); bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; settle();
        check("t4_c3_req", 32'(bus.imem_req), 32'd0);
        check("t4_c3_pc",  bus.out_pc,        32'h0);
        cyc(); bus.redirect_valid = 1'b0; settle();
        check("t4_c4_ov",   32'(bus.out_valid), 32'd0);
        check("t4_c4_addr", bus.imem_addr,      32'h200);
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300; settle();
        check("t4_c5_pc",   bus.out_pc,    32'h200);
        check("t4_c5_addr", bus.imem_addr, 32'h204);
        cyc(); bus.redirect_valid = 1'b0; settle();
        check("t4_c6_ov",   32'(bus.out_valid), 32'd0);
        check("t4_c6_addr", bus.imem_addr,      32'h300);
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; settle();
        check("t4_c7_pc", bus.out_pc, 32'h300);
        cyc(); bus.redirect_valid = 1'b0; settle();
        $display("T5 pc wrap");
        check("t5_c8_ov",   32'(bus.out_valid), 32'd0);
        check("t5_c8_addr", bus.imem_addr,      32'hFFFF_FFFC);
        cyc(); settle();
        check("t5_c9_addr",  bus.imem_addr, 32'h0);
        check("t5_c9_pc",    bus.out_pc,    32'hFFFF_FFFC);
        check("t5_c9_instr", bus.out_instr, 32'hECA8_6423);
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103; settle();
        check("t5_c10_pc", bus.out_pc, 32'h0);

        // ---- misaligned redirect target ----
        cyc(); bus.redirect_valid = 1'b0; settle();
        $display("T6 misaligned redirect");
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_c11_addr", bus.imem_addr,     32'h100);
        check("t6_c11_err",  32'(misalign_err), 32'd1);
        cyc(); settle();
        check("t6_c12_err", 32'(misalign_err), 32'd0);
        check("t6_c12_pc",  bus.out_pc,        32'h100);
`else
        check("t6_c11_addr", bus.imem_addr, 32'h103);
        cyc(); settle();
        check("t6_c12_pc", bus.out_pc, 32'h103);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
